count_enable_gen: RTL

Programmable strobe generator that sits directly upstream of the 4-bit `counter` and drives its `enable` input. On a start request it issues a burst of `len` single-cycle enable strobes spaced `div` clocks apart, then reports completion. It lets the processor sequence counting windows without holding `enable` by software.

---
 rtl/count_enable_gen_pkg.sv | 15 +
 rtl/count_enable_gen_prescaler.sv | 30 +++
 rtl/count_enable_gen.sv | 126 ++++++++++++
 3 files changed

// File: rtl/count_enable_gen_pkg.sv
// Shared types and constants for the counter enable strobe generator.
// Holds the FSM state encoding, default widths and the minimum divide ratio.
package count_enable_gen_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam int DIV_W_DEF = 8;
    localparam int LEN_W_DEF = 8;
    localparam int DIV_MIN   = 1;

endpackage

// File: rtl/count_enable_gen_prescaler.sv
// Wrap counter 0..ratio-1 setting strobe spacing for count_enable_gen.
// Ports: clock, reset_n, clr (sync clear), en (count), ratio, tick (terminal).
module count_enable_gen_prescaler
    import count_enable_gen_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] ratio,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = en && (cnt == ratio - DIV_W'(1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/count_enable_gen.sv
// Burst strobe generator driving the 4-bit counter's enable input.
// Ports: clock, reset_n, start, abort, div, len -> enable, busy, done,
// pulses_left. COUNT_ENABLE_GEN_REPEAT_EN adds input repeat_en.
module count_enable_gen
    import count_enable_gen_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
`ifdef COUNT_ENABLE_GEN_REPEAT_EN
    input  logic             repeat_en,
`endif
    input  logic [DIV_W-1:0] div,
    input  logic [LEN_W-1:0] len,
    output logic             enable,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] pulses_left
);

    state_t           state;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_eff;
    logic             tick;
    logic             run;
`ifdef COUNT_ENABLE_GEN_REPEAT_EN
    logic [LEN_W-1:0] len_q;
    logic             aborted;
`endif

    assign div_eff = (div == '0) ? DIV_W'(DIV_MIN) : div;
    assign run     = (state == S_RUN);

    // Prescaler sits at 0 outside RUN, so every burst starts a fresh period.
    count_enable_gen_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (!run),
        .en      (run),
        .ratio   (div_q),
        .tick    (tick)
    );

    // Abort must suppress a strobe in the very cycle it is sampled.
    assign enable = run && tick && !abort;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            div_q       <= '0;
            pulses_left <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef COUNT_ENABLE_GEN_REPEAT_EN
            len_q       <= '0;
            aborted     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        div_q       <= div_eff;
                        pulses_left <= len;
                        busy        <= 1'b1;
`ifdef COUNT_ENABLE_GEN_REPEAT_EN
                        len_q       <= len;
                        aborted     <= 1'b0;
`endif
                        if (len == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state <= S_DONE;
                        done  <= 1'b1;
`ifdef COUNT_ENABLE_GEN_REPEAT_EN
                        aborted <= 1'b1;
`endif
                    end else if (tick) begin
                        pulses_left <= pulses_left - LEN_W'(1);
                        if (pulses_left == LEN_W'(1)) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
`ifdef COUNT_ENABLE_GEN_REPEAT_EN
                    if (repeat_en && !aborted) begin
                        pulses_left <= len_q;
                        // Zero-length repeats would underflow in RUN.
                        if (len_q == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
`else
                    state <= S_IDLE;
                    busy  <= 1'b0;
`endif
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
